// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic SEL_FETCH = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data grants made while fetch waits; at_max forces fetch to win.
module starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                sel
);

    arb_state_t state, state_next;
    logic       at_max;
    logic       starve_inc;
    logic       starve_clr;

    starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .at_max(at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_gnt) begin
                    state_next = BUSY_D;
                end else if (if_gnt) begin
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Data wins ties unless fetch has already been passed over STARVE_MAX times.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (state == IDLE) begin
            if_gnt = if_req && (!d_req || at_max);
            d_gnt  = d_req && !(if_req && at_max);
        end
    end

    assign starve_inc = d_gnt && if_req;
    assign starve_clr = if_gnt || !if_req;
    assign if_stall   = if_req && !if_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            sel       <= SEL_FETCH;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_gnt) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        sel       <= SEL_DATA;
                    end else if (if_gnt) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                        sel       <= SEL_FETCH;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_be   <= '0;
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        d_valid <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change on the falling edge, checks run 1ns later.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        sel;

    int tests_run;
    int tests_failed;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .sel      (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk); #1;
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        tests_run++; if ({mem_we, mem_be, sel} !== 6'b0) begin tests_failed++; $display("[TB] FAIL reset_ctrl: got %b expected 000000", {mem_we, mem_be, sel}); end
        tests_run++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_addr_wdata: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        tests_run++; if ({if_valid, d_valid, if_gnt, d_gnt} !== 4'b0) begin tests_failed++; $display("[TB] FAIL reset_handshake: got %b expected 0000", {if_valid, d_valid, if_gnt, d_gnt}); end
        tests_run++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, d_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch_basic();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        tests_run++; if ({if_gnt, d_gnt} !== 2'b10) begin tests_failed++; $display("[TB] FAIL fetch_gnt: got %b expected 10", {if_gnt, d_gnt}); end
        @(negedge clk); #1;
        tests_run++; if (mem_req !== 1'b1 || sel !== 1'b0) begin tests_failed++; $display("[TB] FAIL fetch_mem_req_sel: got %b%b expected 10", mem_req, sel); end
        tests_run++; if (mem_addr !== 32'h100) begin tests_failed++; $display("[TB] FAIL fetch_mem_addr: got %h expected 00000100", mem_addr); end
        tests_run++; if (mem_we !== 1'b0 || mem_be !== 4'hF) begin tests_failed++; $display("[TB] FAIL fetch_we_be: got %b/%h expected 0/f", mem_we, mem_be); end
        tests_run++; if (if_stall !== 1'b1 || if_gnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL fetch_busy_stall: got stall=%b gnt=%b expected 1/0", if_stall, if_gnt); end
        @(negedge clk); #1;
        tests_run++; if (if_valid !== 1'b1 || if_rdata !== 32'h0000_0013) begin tests_failed++; $display("[TB] FAIL fetch_valid_rdata: got %b/%h expected 1/00000013", if_valid, if_rdata); end
        tests_run++; if (if_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL fetch_stall_clear: got %b expected 0", if_stall); end
        #1 if_req = 1'b0;
        @(negedge clk); #1;
        tests_run++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL fetch_pulse_end: got valid=%b req=%b expected 0/0", if_valid, mem_req); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        tests_run++; if ({if_gnt, d_gnt} !== 2'b01) begin tests_failed++; $display("[TB] FAIL prio_gnt: got %b expected 01", {if_gnt, d_gnt}); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        tests_run++; if (sel !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL prio_data_access: got sel=%b addr=%h we=%b expected 1/00002000/0", sel, mem_addr, mem_we); end
        @(negedge clk);
        mem_rdata = 32'h0000_0093;
        #1;
        tests_run++; if (d_valid !== 1'b1 || d_rdata !== 32'hCAFE_0001) begin tests_failed++; $display("[TB] FAIL prio_load_data: got %b/%h expected 1/cafe0001", d_valid, d_rdata); end
        tests_run++; if (if_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL prio_fetch_next: got %b expected 1", if_gnt); end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        tests_run++; if (sel !== 1'b0 || mem_addr !== 32'h104) begin tests_failed++; $display("[TB] FAIL prio_fetch_access: got sel=%b addr=%h expected 0/00000104", sel, mem_addr); end
        @(negedge clk); #1;
        tests_run++; if (if_valid !== 1'b1 || if_rdata !== 32'h93 || d_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL prio_fetch_done: got ivalid=%b rdata=%h dvalid=%b expected 1/00000093/0", if_valid, if_rdata, d_valid); end
    endtask

    task automatic test_store_wait();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        mem_ready = 1'b0; mem_rdata = 32'h1111_1111;
        #1;
        tests_run++; if (d_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL store_gnt: got %b expected 1", d_gnt); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d_req = 1'b0;
            mem_ready = (i == 3);
            #1;
            tests_run++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h3000 || sel !== 1'b1 || d_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL store_stable[%0d]: got req=%b we=%b be=%b wdata=%h addr=%h sel=%b dvalid=%b expected 1/1/0011/deadbeef/00003000/1/0", i, mem_req, mem_we, mem_be, mem_wdata, mem_addr, sel, d_valid);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        tests_run++; if (d_valid !== 1'b1 || d_rdata !== 32'hCAFE_0001) begin tests_failed++; $display("[TB] FAIL store_done: got %b/%h expected 1/cafe0001", d_valid, d_rdata); end
        tests_run++; if ({mem_req, mem_we, mem_be} !== 6'b0) begin tests_failed++; $display("[TB] FAIL store_idle_clear: got %b expected 000000", {mem_req, mem_we, mem_be}); end
        tests_run++; if (sel !== 1'b1) begin tests_failed++; $display("[TB] FAIL store_sel_hold: got %b expected 1", sel); end
        @(negedge clk); #1;
        tests_run++; if (d_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_pulse_end: got %b expected 0", d_valid); end
    endtask

    task automatic test_starvation();
        logic exp_fetch;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; if_req = 1'b1; if_addr = 32'h200;
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        for (int k = 0; k < 10; k++) begin
            exp_fetch = ((k % 5) == 4);
            if (k != 0) @(negedge clk);
            #1;
            tests_run++; if ({if_gnt, d_gnt} !== {exp_fetch, ~exp_fetch}) begin tests_failed++; $display("[TB] FAIL starve_gnt[%0d]: got %b expected %b", k, {if_gnt, d_gnt}, {exp_fetch, ~exp_fetch}); end
            @(negedge clk); #1;
            tests_run++; if (sel !== ~exp_fetch || mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL starve_sel[%0d]: got sel=%b req=%b expected %b/1", k, sel, mem_req, ~exp_fetch); end
        end
        @(negedge clk);
        d_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; mem_ready = 1'b0;
        #1;
        tests_run++; if (d_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_gnt: got %b expected 1", d_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_busy: got %b expected 1", mem_req); end
        #1 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        tests_run++; if ({mem_req, sel, mem_we, mem_be} !== 7'b0 || mem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL rstmid_async: got ctrl=%b addr=%h expected 0000000/00000000", {mem_req, sel, mem_we, mem_be}, mem_addr); end
        tests_run++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL rstmid_rdata: got %h/%h expected 0/0", d_rdata, if_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        tests_run++; if (d_valid !== 1'b0 || mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_no_valid: got valid=%b req=%b expected 0/0", d_valid, mem_req); end
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h300; mem_rdata = 32'h0000_ABCD;
        #1;
        tests_run++; if (if_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_fetch_gnt: got %b expected 1", if_gnt); end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        tests_run++; if (mem_addr !== 32'h300 || sel !== 1'b0 || mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_fetch_access: got addr=%h sel=%b req=%b expected 00000300/0/1", mem_addr, sel, mem_req); end
        @(negedge clk); #1;
        tests_run++; if (if_valid !== 1'b1 || if_rdata !== 32'h0000_ABCD || d_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_fetch_done: got ivalid=%b rdata=%h dvalid=%b expected 1/0000abcd/0", if_valid, if_rdata, d_valid); end
    endtask

    task automatic test_ready_idle();
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        tests_run++; if ({if_gnt, d_gnt} !== 2'b00) begin tests_failed++; $display("[TB] FAIL idle_ready_gnt: got %b expected 00", {if_gnt, d_gnt}); end
        @(negedge clk); #1;
        tests_run++; if ({mem_req, if_valid, d_valid} !== 3'b000) begin tests_failed++; $display("[TB] FAIL idle_ready_outputs: got %b expected 000", {mem_req, if_valid, d_valid}); end
        tests_run++; if (if_rdata !== 32'h0000_ABCD || d_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL idle_ready_rdata: got %h/%h expected 0000abcd/00000000", if_rdata, d_rdata); end
        @(negedge clk);
        mem_ready = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000;
        #1;
        tests_run++; if (d_gnt !== 1'b1 || if_valid !== 1'b0 || d_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_ready_still_idle: got gnt=%b ivalid=%b dvalid=%b expected 1/0/0", d_gnt, if_valid, d_valid); end
        @(negedge clk);
        d_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk); #1;
        tests_run++; if (d_valid !== 1'b1 || d_rdata !== 32'h7777_7777) begin tests_failed++; $display("[TB] FAIL idle_ready_followup: got %b/%h expected 1/77777777", d_valid, d_rdata); end
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_fetch_basic();
        test_priority();
        test_store_wait();
        test_starvation();
        test_reset_mid_access();
        test_ready_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
